// File: rtl/led_sequencer.sv
// Start/pause/stop sequencer driving the four board LEDs with selectable patterns.
// Optional LED_PWM_EN adds a DUTY input that dims the LEDs with a 16-step PWM.
module led_sequencer #(
    parameter int STEP_DIV = 1500000,
    parameter int CNT_W    = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             STOP,
    input  logic [1:0]       MODE_SEL,
`ifdef LED_PWM_EN
    input  logic [3:0]       DUTY,
`endif
    output logic             LED0,
    output logic             LED1,
    output logic             LED2,
    output logic             LED3,
    output logic             BUSY,
    output logic             STEP_TICK,
    output logic [CNT_W-1:0] STEP_CNT
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    localparam logic [23:0] PRESC_LAST = 24'(STEP_DIV - 1);

    state_t      state, state_nxt;
    logic [1:0]  mode;
    logic [3:0]  pattern, pat_step;
    logic        dir_down, dir_step;
    logic [23:0] presc;
    logic        step;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // STOP is tested first everywhere so it wins over a simultaneous START.
    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        case (state)
            IDLE:    if (START && !STOP) state_nxt = RUN;
            RUN:     if (STOP) state_nxt = PAUSE;
                     else if (presc == PRESC_LAST) step = 1'b1;
            PAUSE:   if (STOP) state_nxt = IDLE;
                     else if (START) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pat_step = pattern;
        dir_step = dir_down;
        case (mode)
            2'd0: pat_step = pattern + 4'd1;
            2'd1: pat_step = {pattern[2:0], pattern[3]};
            2'd2: begin
                pat_step = dir_down ? (pattern >> 1) : (pattern << 1);
                if (pat_step == 4'b1000)      dir_step = 1'b1;
                else if (pat_step == 4'b0001) dir_step = 1'b0;
            end
            default: pat_step = ~pattern;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode      <= 2'd0;
            pattern   <= 4'b0000;
            dir_down  <= 1'b0;
            presc     <= 24'd0;
            STEP_CNT  <= '0;
            STEP_TICK <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            STEP_TICK <= step;
            BUSY      <= (state_nxt != IDLE);
            if (state == IDLE && state_nxt == RUN) begin
                mode     <= MODE_SEL;
                presc    <= 24'd0;
                STEP_CNT <= '0;
                dir_down <= 1'b0;
                case (MODE_SEL)
                    2'd0:    pattern <= 4'b0000;
                    2'd3:    pattern <= 4'b1111;
                    default: pattern <= 4'b0001;
                endcase
            end else if (state == PAUSE && state_nxt == IDLE) begin
                pattern  <= 4'b0000;
                presc    <= 24'd0;
                STEP_CNT <= '0;
                dir_down <= 1'b0;
            end else if (state == RUN && state_nxt == RUN) begin
                // Prescaler only advances on RUN->RUN cycles, so a pause/resume
                // neither loses nor duplicates a step.
                if (step) begin
                    presc    <= 24'd0;
                    pattern  <= pat_step;
                    dir_down <= dir_step;
                    STEP_CNT <= STEP_CNT + 1'b1;
                end else begin
                    presc <= presc + 24'd1;
                end
            end
        end
    end

`ifdef LED_PWM_EN
    logic [3:0] pwm;
    logic [3:0] led_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pwm   <= 4'd0;
            led_q <= 4'b0000;
        end else begin
            pwm   <= pwm + 4'd1;
            led_q <= pattern & {4{pwm < DUTY}};
        end
    end

    assign {LED0, LED1, LED2, LED3} = led_q;
`else
    assign {LED0, LED1, LED2, LED3} = pattern;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: step-count based pattern model checked every cycle,
// plus directed sequences with literal expectations.
module tb_led_sequencer;

    localparam int DIV = 4;

    logic       CLK, RST_N, START, STOP;
    logic [1:0] MODE_SEL;
    logic       LED0, LED1, LED2, LED3, BUSY, STEP_TICK;
    logic [7:0] STEP_CNT;
`ifdef LED_PWM_EN
    logic [3:0] DUTY;
`endif

    led_sequencer #(.STEP_DIV(DIV), .CNT_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .MODE_SEL(MODE_SEL),
`ifdef LED_PWM_EN
        .DUTY(DUTY),
`endif
        .LED0(LED0), .LED1(LED1), .LED2(LED2), .LED3(LED3),
        .BUSY(BUSY), .STEP_TICK(STEP_TICK), .STEP_CNT(STEP_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors = 0;
    int errors  = 0;

    // Model: the pattern is a pure function of mode and total steps taken.
    bit         m_busy = 0, m_paused = 0, m_tick = 0;
    int         m_mode = 0, m_ph = 0, m_total = 0;
    logic [7:0] m_cnt = 0;
    logic [3:0] m_led = 0;
    int         m_pwm = 0;

    function automatic logic [3:0] pat_of(bit busy, int mode, int total);
        logic [3:0] bounce [6] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2};
        if (!busy) return 4'd0;
        case (mode)
            0:       return 4'(total % 16);
            1:       return 4'(1 << (total % 4));
            2:       return bounce[total % 6];
            default: return (total % 2 == 0) ? 4'hF : 4'h0;
        endcase
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_busy = 0; m_paused = 0; m_tick = 0; m_mode = 0;
            m_ph = 0; m_total = 0; m_cnt = 0; m_led = 0; m_pwm = 0;
        end else begin
`ifdef LED_PWM_EN
            m_led = pat_of(m_busy, m_mode, m_total) & ((m_pwm < int'(DUTY)) ? 4'hF : 4'h0);
            m_pwm = (m_pwm + 1) % 16;
`endif
            m_tick = 0;
            if (!m_busy) begin
                if (START && !STOP) begin
                    m_busy = 1; m_paused = 0; m_mode = int'(MODE_SEL);
                    m_ph = 0; m_total = 0; m_cnt = 0;
                end
            end else if (!m_paused) begin
                if (STOP) m_paused = 1;
                else if (m_ph == DIV - 1) begin
                    m_ph = 0; m_total++; m_cnt++; m_tick = 1;
                end else m_ph++;
            end else begin
                if (STOP) begin
                    m_busy = 0; m_paused = 0; m_ph = 0; m_total = 0; m_cnt = 0;
                end else if (START) m_paused = 0;
            end
`ifndef LED_PWM_EN
            m_led = pat_of(m_busy, m_mode, m_total);
`endif
        end
    end

    function automatic logic [3:0] leds();
        return {LED0, LED1, LED2, LED3};
    endfunction

    always @(negedge CLK) begin
        if (RST_N) begin
            vectors++;
            if ({leds(), BUSY, STEP_TICK, STEP_CNT} !== {m_led, m_busy, m_tick, m_cnt}) begin
                errors++;
                $display("FAIL model t=%0t: got led=%b busy=%b tick=%b cnt=%0d, expected led=%b busy=%b tick=%b cnt=%0d",
                         $time, leds(), BUSY, STEP_TICK, STEP_CNT, m_led, m_busy, m_tick, m_cnt);
            end
        end
    end

    task automatic check(string name, int got, int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_led(string name, logic [3:0] exp);
`ifndef LED_PWM_EN
        check(name, int'(leds()), int'(exp));
`endif
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic pulse(bit s, bit p);
        START = s; STOP = p;
        @(negedge CLK);
        START = 0; STOP = 0;
    endtask

    task automatic wait_tick(output int k);
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!STEP_TICK && k < 50);
        if (!STEP_TICK) check("tick_timeout", 0, 1);
    endtask

    task automatic clear();
        pulse(0, 1);
        pulse(0, 1);
        check("clear_busy", BUSY, 0);
        check_led("clear_led", 4'b0000);
        check("clear_cnt", STEP_CNT, 0);
    endtask

    initial begin
        int k, ticks;
        logic [3:0] chase_exp [5]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [3:0] bounce_exp [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                       4'b0010, 4'b0001, 4'b0010, 4'b0100};
        RST_N = 0; START = 0; STOP = 0; MODE_SEL = 0;
`ifdef LED_PWM_EN
        DUTY = 4'd15;
`endif
        repeat (2) @(negedge CLK);
        check_led("rst_led", 4'b0000);
        check("rst_busy", BUSY, 0);
        check("rst_tick", STEP_TICK, 0);
        check("rst_cnt", STEP_CNT, 0);
        RST_N = 1;
        @(negedge CLK);

        // chase, with MODE_SEL changed mid-run
        MODE_SEL = 2'd1;
        pulse(1, 0);
        check("chase_busy", BUSY, 1);
        check_led("chase_init", 4'b0001);
        for (int i = 0; i < 5; i++) begin
            wait_tick(k);
            check("chase_gap", k, 4);
            check_led("chase_led", chase_exp[i]);
            check("chase_cnt", STEP_CNT, i + 1);
        end
        MODE_SEL = 2'd3;
        wait_tick(k);
        check_led("mode_hold", 4'b0100);
        clear();

        // bounce
        MODE_SEL = 2'd2;
        pulse(1, 0);
        for (int i = 0; i < 8; i++) begin
            wait_tick(k);
            check_led("bounce_led", bounce_exp[i]);
        end
        clear();

        // binary with pause at prescaler=1, then resume
        MODE_SEL = 2'd0;
        pulse(1, 0);
        wait_tick(k);
        wait_tick(k);
        check_led("bin_2", 4'b0010);
        @(negedge CLK);
        pulse(0, 1);
        ticks = 0;
        repeat (20) begin
            @(negedge CLK);
            if (STEP_TICK) ticks++;
        end
        check("pause_ticks", ticks, 0);
        check_led("pause_led", 4'b0010);
        check("pause_busy", BUSY, 1);
        pulse(1, 0);
        wait_tick(k);
        check("resume_gap", k, 3);
        check_led("resume_led", 4'b0011);
        check("resume_cnt", STEP_CNT, 3);

        // asynchronous reset mid-run at pattern 0101
        wait_tick(k);
        wait_tick(k);
        check_led("bin_5", 4'b0101);
        #2 RST_N = 0;
        #1;
        check_led("async_led", 4'b0000);
        check("async_busy", BUSY, 0);
        check("async_cnt", STEP_CNT, 0);
        @(negedge CLK);
        RST_N = 1;
        @(negedge CLK);

        // START and STOP together
        pulse(1, 1);
        check("both_idle", BUSY, 0);
        pulse(1, 0);
        repeat (2) @(negedge CLK);
        pulse(1, 1);
        check("both_run", BUSY, 1);
        ticks = 0;
        repeat (8) begin
            @(negedge CLK);
            if (STEP_TICK) ticks++;
        end
        check("both_pause", ticks, 0);
        pulse(0, 1);
        check("stop2_busy", BUSY, 0);
        check_led("stop2_led", 4'b0000);
        check("stop2_cnt", STEP_CNT, 0);

        // flash
        MODE_SEL = 2'd3;
        pulse(1, 0);
        check_led("flash_init", 4'b1111);
        wait_tick(k);
        check_led("flash_1", 4'b0000);
        wait_tick(k);
        check_led("flash_2", 4'b1111);
        clear();

        // STEP_CNT wrap after 256 steps
        MODE_SEL = 2'd0;
        pulse(1, 0);
        for (int i = 0; i < 255; i++) wait_tick(k);
        check("cnt_255", STEP_CNT, 255);
        wait_tick(k);
        check("cnt_wrap", STEP_CNT, 0);
        check_led("wrap_led", 4'b0000);
        clear();

`ifdef LED_PWM_EN
        MODE_SEL = 2'd3;
        DUTY = 4'd4;
        pulse(1, 0);
        pulse(0, 1);
        repeat (2) @(negedge CLK);
        ticks = 0;
        repeat (16) begin
            @(negedge CLK);
            if (LED0) ticks++;
        end
        check("pwm_duty4", ticks, 4);
        DUTY = 4'd0;
        repeat (2) @(negedge CLK);
        ticks = 0;
        repeat (16) begin
            @(negedge CLK);
            if (leds() != 4'b0000) ticks++;
        end
        check("pwm_duty0", ticks, 0);
        pulse(0, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
